// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider_param.
// The div_signed field exists only when SEQ_DIVIDER_SIGNED_EN is defined.
interface seq_divider_if #(
    parameter int unsigned W    = 16,
    parameter int unsigned FRAC = 8
);
    localparam int unsigned QW = W + FRAC;

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          out_valid;
    logic          out_ready;
    logic [QW-1:0] quotient;
    logic [W-1:0]  remainder;
    logic          div_by_zero;
    logic          busy;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic          div_signed;
`endif

    modport master (
`ifdef SEQ_DIVIDER_SIGNED_EN
        output div_signed,
`endif
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );

    modport slave (
`ifdef SEQ_DIVIDER_SIGNED_EN
        input  div_signed,
`endif
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );
endinterface

// File: rtl/seq_divider_param.sv
// Multi-cycle restoring divider: quotient = (dividend << FRAC) / divisor, one bit per cycle.
// Define SEQ_DIVIDER_SIGNED_EN to add two's-complement operands (one extra fix-up cycle).
module seq_divider_param #(
    parameter int unsigned W    = 16,
    parameter int unsigned FRAC = 8
) (
    input logic          clk,
    input logic          rst,
    seq_divider_if.slave bus
);
    localparam int unsigned QW = W + FRAC;
    localparam int unsigned CW = $clog2(QW + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e        state_q, state_d;
    logic [QW-1:0] dvd_q, dvd_d;
    logic [QW-1:0] quot_q, quot_d;
    logic [W-1:0]  part_q, part_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dbz_q, dbz_d;

    logic [W-1:0]  mag_a, mag_b;
    logic [W:0]    shifted, trial;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_a, neg_b, sat_now;
    logic neg_quot_q, neg_quot_d;
    logic neg_rem_q, neg_rem_d;
    logic sat_q, sat_d;

    assign neg_a   = bus.div_signed & bus.dividend[W-1];
    assign neg_b   = bus.div_signed & bus.divisor[W-1];
    assign mag_a   = neg_a ? -bus.dividend : bus.dividend;
    assign mag_b   = neg_b ? -bus.divisor : bus.divisor;
    // Most negative / -1 overflows the positive quotient range.
    assign sat_now = neg_a & neg_b & (bus.dividend == {1'b1, {(W-1){1'b0}}}) &
                     (bus.divisor == {W{1'b1}});
`else
    assign mag_a = bus.dividend;
    assign mag_b = bus.divisor;
`endif

    // Partial remainder always stays below the divisor, so trial[W] is a clean borrow flag.
    assign shifted = {part_q, dvd_q[QW-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        quot_d  = quot_q;
        part_d  = part_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        sat_d      = sat_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    dvs_d  = mag_b;
                    dvd_d  = QW'(mag_a) << FRAC;
                    part_d = '0;
                    quot_d = '0;
                    cnt_d  = '0;
                    dbz_d  = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                    neg_quot_d = neg_a ^ neg_b;
                    neg_rem_d  = neg_a;
                    sat_d      = sat_now;
`endif
                    if (bus.divisor == '0) begin
                        quot_d  = '1;
                        part_d  = bus.dividend;
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                dvd_d = dvd_q << 1;
                if (!trial[W]) begin
                    part_d = trial[W-1:0];
                    quot_d = {quot_q[QW-2:0], 1'b1};
                end else begin
                    part_d = shifted[W-1:0];
                    quot_d = {quot_q[QW-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(QW - 1)) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    state_d = StFix;
`else
                    state_d = StDone;
`endif
                end
            end
            StFix: begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                if (sat_q) begin
                    quot_d = {1'b0, {(QW-1){1'b1}}};
                    part_d = '0;
                end else begin
                    if (neg_quot_q) quot_d = -quot_q;
                    if (neg_rem_q)  part_d = -part_q;
                end
                state_d = StDone;
`else
                state_d = StIdle;
`endif
            end
            StDone: begin
                if (bus.out_ready) begin
                    dbz_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            dvd_q   <= '0;
            quot_q  <= '0;
            part_q  <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            quot_q  <= quot_d;
            part_q  <= part_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

`ifdef SEQ_DIVIDER_SIGNED_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            sat_q      <= sat_d;
        end
    end
`endif

    assign bus.in_ready    = (state_q == StIdle);
    assign bus.out_valid   = (state_q == StDone);
    assign bus.busy        = (state_q != StIdle);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = part_q;
    assign bus.div_by_zero = dbz_q & (state_q == StDone);
endmodule

// File: tb/tb_seq_divider_param.sv
// Randomized self-checking bench for seq_divider_param against an arithmetic reference model.
module tb_seq_divider_param;
    localparam int unsigned W    = 16;
    localparam int unsigned FRAC = 8;
    localparam int unsigned QW   = W + FRAC;
`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam int LAT = QW + 1;
`else
    localparam int LAT = QW;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_divider_if #(.W(W), .FRAC(FRAC)) bus ();

    seq_divider_param #(.W(W), .FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                  output logic [QW-1:0] q, output logic [W-1:0] r);
        longint sa, sb, num, min_a;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (!sgn) begin
            num = longint'(a) * (longint'(1) << FRAC);
            q   = QW'(num / longint'(b));
            r   = W'(num % longint'(b));
        end else begin
            sa    = longint'($signed(a));
            sb    = longint'($signed(b));
            min_a = -(longint'(1) << (W - 1));
            if (sa == min_a && sb == -1) begin
                q = QW'((longint'(1) << (QW - 1)) - 1);
                r = '0;
            end else begin
                num = sa * (longint'(1) << FRAC);
                q   = QW'(num / sb);
                r   = W'(num % sb);
            end
        end
    endfunction

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                           input int hold, input string tag);
        logic [QW-1:0] eq;
        logic [W-1:0]  er;
        int n;
        int exp_lat;
        model(a, b, sgn, eq, er);
        exp_lat = (b == '0) ? 0 : LAT;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
`ifdef SEQ_DIVIDER_SIGNED_EN
        bus.div_signed = sgn;
`endif
        check_eq({tag, ":in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
`ifdef SEQ_DIVIDER_SIGNED_EN
        bus.div_signed = 1'($urandom);
`endif
        n = 0;
        while (!bus.out_valid && n < 4 * QW) begin
            bus.out_ready = 1'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        bus.out_ready = 1'b0;
        check_eq({tag, ":latency"}, 64'(n), 64'(exp_lat));
        check_eq({tag, ":quotient"}, 64'(bus.quotient), 64'(eq));
        check_eq({tag, ":remainder"}, 64'(bus.remainder), 64'(er));
        check_eq({tag, ":dbz"}, 64'(bus.div_by_zero), 64'(b == '0));
        check_eq({tag, ":busy"}, 64'(bus.busy), 64'd1);
        bus.in_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq({tag, ":hold_valid"}, 64'(bus.out_valid), 64'd1);
            check_eq({tag, ":hold_quot"}, 64'(bus.quotient), 64'(eq));
            check_eq({tag, ":hold_rem"}, 64'(bus.remainder), 64'(er));
            check_eq({tag, ":hold_in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check_eq({tag, ":released"}, 64'(bus.out_valid), 64'd0);
        check_eq({tag, ":rel_in_ready"}, 64'(bus.in_ready), 64'd1);
        check_eq({tag, ":rel_dbz"}, 64'(bus.div_by_zero), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] a, b;
        logic         sgn;
        int           sel;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        bus.div_signed = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset:out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("reset:in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("reset:busy", 64'(bus.busy), 64'd0);
        check_eq("reset:quotient", 64'(bus.quotient), 64'd0);
        check_eq("reset:remainder", 64'(bus.remainder), 64'd0);
        check_eq("reset:dbz", 64'(bus.div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Abort an in-flight division with an asynchronous reset.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = 16'd100;
        bus.divisor  = 16'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check_eq("midcalc:busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("midrst:out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("midrst:quotient", 64'(bus.quotient), 64'd0);
        check_eq("midrst:in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("midrst:busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div(16'd100, 16'd7, 1'b0, 0, "100/7");
        run_div(16'd65535, 16'd1, 1'b0, 0, "65535/1");
        run_div(16'd0, 16'd5, 1'b0, 0, "0/5");
        run_div(16'd1, 16'd65535, 1'b0, 0, "1/65535");
        run_div(16'd1234, 16'd0, 1'b0, 2, "1234/0");
        run_div(16'd100, 16'd7, 1'b0, 10, "backpressure");
`ifdef SEQ_DIVIDER_SIGNED_EN
        run_div(-16'sd100, 16'd7, 1'b1, 0, "s-100/7");
        run_div(16'h8000, 16'hFFFF, 1'b1, 0, "s-min/-1");
        run_div(16'hFC00, 16'd0, 1'b1, 0, "s/0");
`endif

        for (int i = 0; i < 24; i++) begin
            a   = W'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0)      b = '0;
            else if (sel < 4)  b = W'($urandom_range(1, 15));
            else               b = W'($urandom);
`ifdef SEQ_DIVIDER_SIGNED_EN
            sgn = 1'($urandom);
`else
            sgn = 1'b0;
`endif
            run_div(a, b, sgn, $urandom_range(0, 3), $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
